// File: rtl/led_chaser.sv
// led_chaser: animated LED indicator for the dice game's result display.
// Decodes the 3-bit win code into chase-up, chase-down, bounce, blink or an
// all-lit idle pattern, advancing one animation step every STEP_DIV clocks.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   win  : mode code (0 idle, 1 chase up, 2 chase down, 3 bounce, 4 blink,
//          5-7 idle)
//   led  : registered LED drive, N_LED wide, polarity set by ACTIVE_LOW
//   step : one-cycle pulse on each cycle the animation state advances
module led_chaser #(
  parameter int N_LED      = 8,
  parameter int STEP_DIV   = 5_000_000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       win,
  output logic [N_LED-1:0] led,
  output logic             step
);

  localparam int PW = $clog2(N_LED);
  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [PW-1:0]    LAST     = PW'(N_LED - 1);
  localparam logic [PW-1:0]    PRE_LAST = PW'(N_LED - 2);
  localparam logic [PW-1:0]    ONE      = PW'(1);
  localparam logic [CW-1:0]    CNT_TOP  = CW'(STEP_DIV - 1);
  localparam logic [N_LED-1:0] MSB_ONE  = {1'b1, {(N_LED-1){1'b0}}};
  localparam logic [N_LED-1:0] IDLE_LED = (ACTIVE_LOW != 0) ? '0 : '1;

  typedef enum logic [2:0] {
    M_IDLE   = 3'd0,
    M_UP     = 3'd1,
    M_DOWN   = 3'd2,
    M_BOUNCE = 3'd3,
    M_BLINK  = 3'd4
  } mode_t;

  mode_t            mode_q;
  mode_t            m;
  logic [PW-1:0]    pos;
  logic             dir;   // 0 = up, 1 = down
  logic [CW-1:0]    cnt;
  logic             ph;
  logic [N_LED-1:0] lit;
  logic             pos_bad;

  always_comb begin
    m = M_IDLE;
    case (win)
      3'd1:    m = M_UP;
      3'd2:    m = M_DOWN;
      3'd3:    m = M_BOUNCE;
      3'd4:    m = M_BLINK;
      default: m = M_IDLE;
    endcase
  end

  // pos 0 is the MSB LED, so the one-hot is a right shift of the MSB bit.
  always_comb begin
    lit = '1;
    case (mode_q)
      M_UP, M_DOWN, M_BOUNCE: lit = MSB_ONE >> pos;
      M_BLINK:                lit = ph ? '1 : '0;
      default:                lit = '1;
    endcase
  end

  // Out-of-range positions only exist when N_LED is not a power of two.
  generate
    if ((1 << PW) == N_LED) begin : g_pow2
      assign pos_bad = 1'b0;
    end else begin : g_guard
      assign pos_bad = (pos > LAST);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= M_IDLE;
      pos    <= '0;
      dir    <= 1'b0;
      cnt    <= '0;
      ph     <= 1'b0;
      step   <= 1'b0;
      led    <= IDLE_LED;
    end else begin
      led <= (ACTIVE_LOW != 0) ? ~lit : lit;
      if (m != mode_q) begin
        mode_q <= m;
        cnt    <= '0;
        step   <= 1'b0;
        case (m)
          M_UP:     pos <= '0;
          M_DOWN:   pos <= LAST;
          M_BOUNCE: begin
            pos <= '0;
            dir <= 1'b0;
          end
          M_BLINK:  ph <= 1'b1;
          default:  ;
        endcase
      end else if (cnt == CNT_TOP) begin
        cnt  <= '0;
        step <= 1'b1;
        case (mode_q)
          M_UP:     pos <= (pos == LAST) ? '0 : pos + ONE;
          M_DOWN:   pos <= (pos == '0) ? LAST : pos - ONE;
          M_BOUNCE: begin
            if (!dir) begin
              if (pos == LAST) begin
                dir <= 1'b1;
                pos <= PRE_LAST;
              end else begin
                pos <= pos + ONE;
              end
            end else begin
              if (pos == '0) begin
                dir <= 1'b0;
                pos <= ONE;
              end else begin
                pos <= pos - ONE;
              end
            end
          end
          M_BLINK:  ph <= ~ph;
          default:  ;
        endcase
      end else begin
        cnt  <= cnt + 1'b1;
        step <= 1'b0;
      end
      if (pos_bad) pos <= '0;
    end
  end

endmodule

// File: tb/tb_led_chaser.sv
// Directed bench for led_chaser: an 8-LED active-low instance with a 4-cycle
// step, and a 2-LED active-high instance with a 1-cycle step.
module tb_led_chaser;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] win0;
  logic [2:0] win1;
  logic [7:0] led0;
  logic       step0;
  logic [1:0] led1;
  logic       step1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_chaser #(.N_LED(8), .STEP_DIV(4), .ACTIVE_LOW(1)) dut0 (
    .clk(clk), .rst(rst), .win(win0), .led(led0), .step(step0)
  );

  led_chaser #(.N_LED(2), .STEP_DIV(1), .ACTIVE_LOW(0)) dut1 (
    .clk(clk), .rst(rst), .win(win1), .led(led1), .step(step1)
  );

  localparam logic [7:0] UP_SEQ [9] =
    '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE, 8'h7F};
  localparam logic [7:0] DN_SEQ [9] =
    '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFE};
  localparam logic [7:0] BN_SEQ [16] =
    '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE,
      8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hBF};
  localparam logic [7:0] BL_SEQ [4] = '{8'h00, 8'hFF, 8'h00, 8'hFF};

  // Cycle n below counts negedges after the load edge (n = 1 follows it).
  // Steps land on n = 5, 9, 13, ...; led shows pattern (n-2)/4 from n = 2.

  task automatic test_reset();
    logic exp_step;
    rst  = 1'b1;
    win0 = 3'd1;
    win1 = 3'd0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (led0 !== 8'h00) begin
        errors++;
        $display("FAIL reset_led0 got %h expected %h", led0, 8'h00);
      end
      checks++;
      if (step0 !== 1'b0) begin
        errors++;
        $display("FAIL reset_step0 got %b expected 0", step0);
      end
      checks++;
      if (led1 !== 2'b11) begin
        errors++;
        $display("FAIL reset_led1 got %b expected 11", led1);
      end
      checks++;
      if (step1 !== 1'b0) begin
        errors++;
        $display("FAIL reset_step1 got %b expected 0", step1);
      end
    end
    rst = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      exp_step = (n == 5);
      checks++;
      if (step0 !== exp_step) begin
        errors++;
        $display("FAIL reset_first_step n=%0d got %b expected %b", n, step0, exp_step);
      end
      if (n >= 2) begin
        checks++;
        if (led0 !== 8'h7F) begin
          errors++;
          $display("FAIL reset_first_led n=%0d got %h expected 7f", n, led0);
        end
      end
    end
  endtask

  task automatic test_chase_up();
    logic exp_step;
    rst  = 1'b1;
    win0 = 3'd1;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 1; n <= 37; n++) begin
      @(negedge clk);
      exp_step = (n >= 5) && (n % 4 == 1);
      checks++;
      if (step0 !== exp_step) begin
        errors++;
        $display("FAIL chase_up_step n=%0d got %b expected %b", n, step0, exp_step);
      end
      if (n >= 2) begin
        checks++;
        if (led0 !== UP_SEQ[(n-2)/4]) begin
          errors++;
          $display("FAIL chase_up_led n=%0d got %h expected %h", n, led0, UP_SEQ[(n-2)/4]);
        end
      end
    end
  endtask

  task automatic test_chase_down();
    logic exp_step;
    win0 = 3'd2;
    for (int n = 1; n <= 37; n++) begin
      @(negedge clk);
      exp_step = (n >= 5) && (n % 4 == 1);
      checks++;
      if (step0 !== exp_step) begin
        errors++;
        $display("FAIL chase_down_step n=%0d got %b expected %b", n, step0, exp_step);
      end
      if (n >= 2) begin
        checks++;
        if (led0 !== DN_SEQ[(n-2)/4]) begin
          errors++;
          $display("FAIL chase_down_led n=%0d got %h expected %h", n, led0, DN_SEQ[(n-2)/4]);
        end
      end
    end
  endtask

  task automatic test_bounce();
    logic exp_step;
    win0 = 3'd3;
    for (int n = 1; n <= 65; n++) begin
      @(negedge clk);
      exp_step = (n >= 5) && (n % 4 == 1);
      checks++;
      if (step0 !== exp_step) begin
        errors++;
        $display("FAIL bounce_step n=%0d got %b expected %b", n, step0, exp_step);
      end
      if (n >= 2) begin
        checks++;
        if (led0 !== BN_SEQ[(n-2)/4]) begin
          errors++;
          $display("FAIL bounce_led n=%0d got %h expected %h", n, led0, BN_SEQ[(n-2)/4]);
        end
      end
    end
  endtask

  task automatic test_blink_idle();
    logic exp_step;
    win0 = 3'd4;
    for (int n = 1; n <= 17; n++) begin
      @(negedge clk);
      if (n >= 2) begin
        checks++;
        if (led0 !== BL_SEQ[(n-2)/4]) begin
          errors++;
          $display("FAIL blink_led n=%0d got %h expected %h", n, led0, BL_SEQ[(n-2)/4]);
        end
      end
    end
    win0 = 3'd0;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      exp_step = (n >= 5) && (n % 4 == 1);
      checks++;
      if (step0 !== exp_step) begin
        errors++;
        $display("FAIL idle_step n=%0d got %b expected %b", n, step0, exp_step);
      end
      if (n >= 2) begin
        checks++;
        if (led0 !== 8'h00) begin
          errors++;
          $display("FAIL idle_led n=%0d got %h expected 00", n, led0);
        end
      end
    end
  endtask

  task automatic test_midcount();
    logic       exp_step;
    logic [7:0] exp_led;
    win0 = 3'd1;
    for (int n = 1; n <= 3; n++) @(negedge clk);
    checks++;
    if (led0 !== 8'h7F) begin
      errors++;
      $display("FAIL midcount_pre_led got %h expected 7f", led0);
    end
    // prescaler is at 2 here; the partial count must be discarded
    win0 = 3'd2;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      exp_step = (n == 5);
      checks++;
      if (step0 !== exp_step) begin
        errors++;
        $display("FAIL midcount_step n=%0d got %b expected %b", n, step0, exp_step);
      end
      if (n >= 2) begin
        exp_led = (n == 6) ? 8'hFD : 8'hFE;
        checks++;
        if (led0 !== exp_led) begin
          errors++;
          $display("FAIL midcount_led n=%0d got %h expected %h", n, led0, exp_led);
        end
      end
    end
  endtask

  task automatic test_edge_params();
    logic       exp_step;
    logic [1:0] exp_led;
    win1 = 3'd1;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      exp_step = (n >= 2);
      case (n)
        1:       exp_led = 2'b11;
        3:       exp_led = 2'b01;
        default: exp_led = 2'b10;
      endcase
      checks++;
      if (step1 !== exp_step) begin
        errors++;
        $display("FAIL edge_step n=%0d got %b expected %b", n, step1, exp_step);
      end
      checks++;
      if (led1 !== exp_led) begin
        errors++;
        $display("FAIL edge_led n=%0d got %b expected %b", n, led1, exp_led);
      end
    end
  endtask

  initial begin
    test_reset();
    test_chase_up();
    test_chase_down();
    test_bounce();
    test_blink_idle();
    test_midcount();
    test_edge_params();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
